// File: rtl/tlp_credit_pkg.sv
// Shared definitions for the TLP credit arbiter: FSM state encoding and
// default parameter values. Optional feature macro used by this block:
// CREDIT_ERR_EN (adds the sticky err output).
package tlp_credit_pkg;

    // Default parameter values
    localparam int WIDTH_DEF  = 8;
    localparam int NREQ_DEF   = 4;
    localparam int SWIDTH_DEF = 4;

    // FSM state encoding, kept as plain constants for older tooling
    typedef logic [0:0] state_t;
    localparam state_t UNINIT = 1'b0;
    localparam state_t RUN    = 1'b1;

endpackage

// File: rtl/tlp_credit_arbiter_credit_counter.sv
// credit_counter: available-credit register for the TLP credit arbiter.
// Handles load, grant decrement, return increment (both in one cycle) and
// saturation at the configured limit. With CREDIT_ERR_EN defined it also
// keeps the sticky err flag (over-limit return, or return while unconfigured).
module credit_counter
    import tlp_credit_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int SWIDTH = SWIDTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic              run,
    input  logic              dec_en,
    input  logic [SWIDTH-1:0] dec_amt,
    input  logic              inc_en,
    input  logic [SWIDTH-1:0] inc_amt,
`ifdef CREDIT_ERR_EN
    output logic              err,
`endif
    output logic [WIDTH-1:0]  avail
);
    // Costs are zero-extended into a WIDTH+1 bit sum; SWIDTH must not exceed WIDTH.
    localparam int PADW = WIDTH + 1 - SWIDTH;

    logic [WIDTH-1:0] limit;
    logic [WIDTH:0]   sum;
    logic             over;

    // Next credit value: subtract the grant, add the return, flag overshoot.
    // The arbiter only grants when the cost fits, so the subtraction cannot wrap.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path infers a latch.
        sum  = {1'b0, avail};
        over = 1'b0;
        if (dec_en) sum = sum - {{PADW{1'b0}}, dec_amt};
        if (run && inc_en) sum = sum + {{PADW{1'b0}}, inc_amt};
        over = (sum > {1'b0, limit});
    end

    // Credit and limit registers; flush clears, load wins over arithmetic.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            avail <= '0;
            limit <= '0;
        end else if (clear) begin
            avail <= '0;
            limit <= '0;
        end else if (load) begin
            avail <= load_value;
            limit <= load_value;
        end else if (over) begin
            avail <= limit;
        end else begin
            avail <= sum[WIDTH-1:0];
        end
    end

`ifdef CREDIT_ERR_EN
    // Sticky error: returns that overshoot the limit or arrive while unconfigured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (clear || load) begin
            err <= 1'b0;
        end else if (inc_en && (!run || over)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/tlp_credit_arbiter.sv
// tlp_credit_arbiter: round-robin credit-gated grant arbiter for NREQ
// requesters. UNINIT/RUN FSM and arbitration live here; credit arithmetic
// lives in credit_counter. Optional macro CREDIT_ERR_EN adds sticky output err.
module tlp_credit_arbiter
    import tlp_credit_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NREQ   = NREQ_DEF,
    parameter int SWIDTH = SWIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_load,
    input  logic [WIDTH-1:0]       cfg_credit,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*SWIDTH-1:0] req_size,
    input  logic                   ret_valid,
    input  logic [SWIDTH-1:0]      ret_count,
    output logic [NREQ-1:0]        gnt,
    output logic [WIDTH-1:0]       avail,
`ifdef CREDIT_ERR_EN
    output logic                   err,
`endif
    output logic                   ready
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PADW = WIDTH + 1 - SWIDTH;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     ptr;
    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   gnt_next;
    logic              win_valid;
    logic [PW-1:0]     win_idx;
    logic [SWIDTH-1:0] win_size;

    // FSM next state: flush beats cfg_load.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = UNINIT;
        end else if (cfg_load) begin
            state_next = RUN;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= UNINIT;
        else        state <= state_next;
    end

    assign ready = (state == RUN);

    // Per-requester eligibility. No grant in the cycle after a grant, and none
    // while the credit pool is being reloaded or flushed.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = (state == RUN) && !flush && !cfg_load && (gnt == '0) &&
                          req[i] && (req_size[i*SWIDTH +: SWIDTH] != '0) &&
                          ({{PADW{1'b0}}, req_size[i*SWIDTH +: SWIDTH]} <= {1'b0, avail});
        end
    end

    // Round-robin pick: first eligible index scanning from ptr upward.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_valid && eligible[(int'(ptr) + k) % NREQ]) begin
                win_valid = 1'b1;
                win_idx   = PW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign win_size = req_size[int'(win_idx)*SWIDTH +: SWIDTH];
    assign gnt_next = win_valid ? (NREQ'(1) << win_idx) : '0;

    // Grant pulse and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt <= '0;
            ptr <= '0;
        end else begin
            gnt <= gnt_next;
            if (win_valid) begin
                ptr <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
            end
        end
    end

    credit_counter #(
        .WIDTH  (WIDTH),
        .SWIDTH (SWIDTH)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (cfg_load && !flush),
        .load_value (cfg_credit),
        .run        (state == RUN),
        .dec_en     (win_valid),
        .dec_amt    (win_size),
        .inc_en     (ret_valid),
        .inc_amt    (ret_count),
`ifdef CREDIT_ERR_EN
        .err        (err),
`endif
        .avail      (avail)
    );

endmodule

// File: doc/tlp_credit_arbiter.md
TLP_CREDIT_ARBITER -- requirements
Module: tlp_credit_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, width of the credit counter and of cfg_credit and avail.
REQ-002 Parameter NREQ, default 4, number of requesters.
REQ-003 Parameter SWIDTH, default 4, width of each per-requester credit cost.
REQ-004 Port clk, input, 1, clock; all state changes on rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-low reset.
REQ-006 Port cfg_load, input, 1, one-cycle pulse that loads the credit limit.
REQ-007 Port cfg_credit, input, WIDTH, credit limit sampled on cfg_load.
REQ-008 Port flush, input, 1, synchronous return to the unconfigured state.
REQ-009 Port req, input, NREQ, per-requester request level, held until granted.
REQ-010 Port req_size, input, NREQ*SWIDTH, credit cost of requester i in bits [i*SWIDTH +: SWIDTH].
REQ-011 Port ret_valid, input, 1, credit return strobe.
REQ-012 Port ret_count, input, SWIDTH, credits returned when ret_valid is high.
REQ-013 Port gnt, output, NREQ, registered one-hot grant pulse, one cycle wide.
REQ-014 Port avail, output, WIDTH, registered available-credit count.
REQ-015 Port ready, output, 1, high while in RUN.

Function
REQ-016 The FSM SHALL have states UNINIT and RUN.
- UNINIT->RUN on cfg_load.
- RUN->UNINIT on flush.
- flush SHALL take priority over cfg_load.
REQ-017 On cfg_load, the block SHALL set limit and avail to cfg_credit at the next edge, from either state; in RUN this clears all outstanding credit.
REQ-018 Eligibility: requester i SHALL be eligible when all of the following hold:
- state is RUN;
- req[i] is high;
- req_size[i] is nonzero;
- req_size[i] <= avail;
- gnt is all-zero this cycle.
REQ-019 Arbitration SHALL be round-robin from pointer ptr (reset 0), granting the first eligible index ptr, ptr+1, ... mod NREQ. Ineligible requesters are skipped, not waited on.
REQ-020 On a grant to index i at an edge:
- gnt SHALL equal one-hot i for exactly the following cycle;
- ptr SHALL become (i+1) mod NREQ;
- avail SHALL decrease by req_size[i] at the same edge.
REQ-021 Requesters SHALL drop req on the edge after seeing gnt. Because of REQ-018, at most one grant is issued every two cycles.
REQ-022 When ret_valid is high in RUN, avail SHALL increase by ret_count at that edge. With a simultaneous grant, avail_next = avail - req_size[i] + ret_count, computed at WIDTH+1 bits.
REQ-023 If avail_next exceeds limit, avail SHALL saturate at limit. ret_valid SHALL be ignored in UNINIT.
REQ-024 A requester with req_size of zero SHALL never be granted.
REQ-025 Latency: req high with sufficient credit at edge N SHALL produce gnt in cycle N+1 (post-edge).

Reset
REQ-026 While reset is low, the block SHALL hold:
- state UNINIT, gnt 0, avail 0, limit 0, ptr 0, ready 0;
- err 0 when CREDIT_ERR_EN is defined.
REQ-027 Reset asserted mid-grant SHALL clear gnt immediately (asynchronously), and no credit is consumed.
REQ-028 After reset release, no grant SHALL occur before a cfg_load.

Configuration
REQ-029 Macro CREDIT_ERR_EN:
- When defined, the block SHALL add output port err (1 bit, sticky). err is set when a return would exceed limit (the REQ-023 saturation case) or when ret_valid is seen in UNINIT.
- err SHALL be cleared by reset, flush or cfg_load.
- When not defined, the err port and its logic SHALL be absent; saturation behaviour is unchanged.

Structure
REQ-030 A shared package tlp_credit_pkg SHALL hold the FSM state encoding (UNINIT, RUN) and default parameter constants (WIDTH 8, NREQ 4, SWIDTH 4).
REQ-031 Credit arithmetic SHALL live in sub-module credit_counter, which handles load, decrement, increment, simultaneous add/subtract and saturation at limit. The arbiter and FSM remain in tlp_credit_arbiter.

Verification
REQ-032 Reset, then req=4'b1111 with no cfg_load -> gnt stays 0, ready 0, avail 0.
REQ-033 cfg_load with cfg_credit=10; all four requesting with size 3 -> grants to 0,1,2 on alternate cycles, avail steps 10->7->4->1, requester 3 never granted while avail=1.
REQ-034 avail=5, ptr=0; req0 size 8, req1 size 2 -> req0 skipped, gnt=4'b0010, avail=3, ptr=2.
REQ-035 avail=4, grant of size 3 with simultaneous ret_valid and ret_count=5, limit 10 -> avail=6.
REQ-036 limit 10, avail 9, ret_count=4 -> avail=10 saturated; err=1 with CREDIT_ERR_EN defined, no err port without it.
REQ-037 flush and cfg_load in the same cycle during RUN -> state UNINIT, ready 0, no further grants. Reset asserted during a gnt cycle -> gnt drops to 0 asynchronously.
